// File: rtl/motion_pkg.sv
// Shared types and constants for the motion-detection pipeline.
package motion_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCUM  = 2'd1;
  localparam state_t ST_REPORT = 2'd2;

  localparam int DEFAULT_PIXELS_PER_FRAME    = 76800;
  localparam int DEFAULT_MOTION_THRESHOLD    = 1000;
  localparam int SUBTRACTOR_PIXEL_THRESHOLD  = 50;

endpackage

// File: rtl/motion_sat_counter.sv
// Saturating up-counter with synchronous clear; next_o exposes the value it will load.
module motion_sat_counter #(
  parameter int COUNT_W = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [COUNT_W-1:0] count_o,
  output logic [COUNT_W-1:0] next_o
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/motion_accumulator.sv
// Counts motion pixels over one frame and reports the total with a valid/ack handshake.
module motion_accumulator
  import motion_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = DEFAULT_PIXELS_PER_FRAME,
  parameter int MOTION_THRESHOLD = DEFAULT_MOTION_THRESHOLD,
  parameter int COUNT_W          = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_difference,
  input  logic               valid_data,
  output logic               ready,
  input  logic               result_ack,
  output logic               result_valid,
  output logic [COUNT_W-1:0] motion_count,
  output logic               motion_detected,
  output logic               busy,
  output logic               protocol_err
);

  localparam logic [COUNT_W-1:0] LAST_PIXEL = COUNT_W'(PIXELS_PER_FRAME - 1);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] pixel_cnt_q, pixel_cnt_d;
  logic               ready_q, ready_d;
  logic               result_valid_q, result_valid_d;
  logic [COUNT_W-1:0] motion_count_q, motion_count_d;
  logic               motion_detected_q, motion_detected_d;
  logic               busy_q, busy_d;
  logic               protocol_err_q, protocol_err_d;

  logic               diff_clear;
  logic               diff_en;
  logic [COUNT_W-1:0] diff_cnt;
  logic [COUNT_W-1:0] diff_next;

  // A new frame starts from IDLE, or straight out of REPORT when ack and start coincide.
  assign diff_clear = start && ((state_q == ST_IDLE) ||
                                ((state_q == ST_REPORT) && result_ack));
  assign diff_en    = (state_q == ST_ACCUM) && valid_data && frame_difference;

  motion_sat_counter #(.COUNT_W(COUNT_W)) u_diff_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (diff_clear),
    .en_i    (diff_en),
    .count_o (diff_cnt),
    .next_o  (diff_next)
  );

  always_comb begin
    state_d           = state_q;
    pixel_cnt_d       = pixel_cnt_q;
    ready_d           = ready_q;
    result_valid_d    = result_valid_q;
    motion_count_d    = motion_count_q;
    motion_detected_d = motion_detected_q;
    busy_d            = busy_q;
    protocol_err_d    = protocol_err_q | (valid_data && (state_q != ST_ACCUM));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ACCUM;
          pixel_cnt_d = '0;
          ready_d     = 1'b1;
          busy_d      = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (valid_data) begin
          pixel_cnt_d = pixel_cnt_q + 1'b1;
          if (pixel_cnt_q == LAST_PIXEL) begin
            // diff_next already includes the final pixel's flag.
            state_d           = ST_REPORT;
            ready_d           = 1'b0;
            result_valid_d    = 1'b1;
            motion_count_d    = diff_next;
            motion_detected_d = (int'(diff_next) >= MOTION_THRESHOLD);
          end
        end
      end
      ST_REPORT: begin
        if (result_ack) begin
          result_valid_d = 1'b0;
          if (start) begin
            state_d     = ST_ACCUM;
            pixel_cnt_d = '0;
            ready_d     = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d        = ST_IDLE;
        ready_d        = 1'b0;
        result_valid_d = 1'b0;
        busy_d         = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      pixel_cnt_q       <= '0;
      ready_q           <= 1'b0;
      result_valid_q    <= 1'b0;
      motion_count_q    <= '0;
      motion_detected_q <= 1'b0;
      busy_q            <= 1'b0;
      protocol_err_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      pixel_cnt_q       <= pixel_cnt_d;
      ready_q           <= ready_d;
      result_valid_q    <= result_valid_d;
      motion_count_q    <= motion_count_d;
      motion_detected_q <= motion_detected_d;
      busy_q            <= busy_d;
      protocol_err_q    <= protocol_err_d;
    end
  end

  assign ready           = ready_q;
  assign result_valid    = result_valid_q;
  assign motion_count    = motion_count_q;
  assign motion_detected = motion_detected_q;
  assign busy            = busy_q;
  assign protocol_err    = protocol_err_q;

endmodule

// File: tb/tb_motion_accumulator.sv
// Self-checking bench: frame table plus handshake, reset and protocol corner sequences.
module tb_motion_accumulator;

  localparam int PPF    = 8;
  localparam int THRESH = 3;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          frame_difference;
  logic          valid_data;
  logic          ready;
  logic          result_ack;
  logic          result_valid;
  logic [CW-1:0] motion_count;
  logic          motion_detected;
  logic          busy;
  logic          protocol_err;

  always #5 clk = ~clk;

  motion_accumulator #(
    .PIXELS_PER_FRAME (PPF),
    .MOTION_THRESHOLD (THRESH),
    .COUNT_W          (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .frame_difference (frame_difference),
    .valid_data       (valid_data),
    .ready            (ready),
    .result_ack       (result_ack),
    .result_valid     (result_valid),
    .motion_count     (motion_count),
    .motion_detected  (motion_detected),
    .busy             (busy),
    .protocol_err     (protocol_err)
  );

  typedef struct packed {
    logic [7:0] flags;
    logic       gaps;
    logic [3:0] exp_cnt;
    logic       exp_det;
  } vec_t;

  typedef struct packed {
    logic [3:0] cnt;
    logic       det;
  } exp_t;

  vec_t vecs [6];
  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;
  logic rv_prev = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and any new result is scored.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (result_valid && !rv_prev) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got result_valid=1 count=%0d expected no result",
                 motion_count);
      end else begin
        e = sb_q.pop_front();
        check("motion_count", int'(motion_count), int'(e.cnt));
        check("motion_detected", int'(motion_detected), int'(e.det));
        $display("result: count=%0d detected=%0d (expected %0d/%0d)",
                 motion_count, motion_detected, e.cnt, e.det);
      end
    end
    rv_prev = result_valid;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("ready_after_start", int'(ready), 1);
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic feed_pixels(input vec_t v);
    exp_t e;
    for (int i = 0; i < PPF; i++) begin
      valid_data       = 1'b1;
      frame_difference = v.flags[i];
      if (i == PPF - 1) begin
        e.cnt = v.exp_cnt;
        e.det = v.exp_det;
        sb_q.push_back(e);
      end
      step();
      valid_data       = 1'b0;
      frame_difference = 1'b0;
      if (i < PPF - 1) begin
        check("ready_accum", int'(ready), 1);
        check("result_valid_accum", int'(result_valid), 0);
        if (v.gaps) step();
      end
    end
    check("result_valid_latency", int'(result_valid), 1);
    check("ready_after_final", int'(ready), 0);
  endtask

  task automatic ack_idle(input int exp_cnt);
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    check("result_valid_after_ack", int'(result_valid), 0);
    check("busy_after_ack", int'(busy), 0);
    step();
    check("motion_count_held", int'(motion_count), exp_cnt);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{flags: 8'b0010_0101, gaps: 1'b0, exp_cnt: 4'd3, exp_det: 1'b1};
    vecs[1] = '{flags: 8'b0010_0101, gaps: 1'b1, exp_cnt: 4'd3, exp_det: 1'b1};
    vecs[2] = '{flags: 8'b0000_0000, gaps: 1'b0, exp_cnt: 4'd0, exp_det: 1'b0};
    vecs[3] = '{flags: 8'b1111_1111, gaps: 1'b1, exp_cnt: 4'd8, exp_det: 1'b1};
    vecs[4] = '{flags: 8'b1000_0001, gaps: 1'b0, exp_cnt: 4'd2, exp_det: 1'b0};
    vecs[5] = '{flags: 8'b0110_1000, gaps: 1'b0, exp_cnt: 4'd3, exp_det: 1'b1};

    reset = 1'b1; start = 1'b0; frame_difference = 1'b0;
    valid_data = 1'b0; result_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset_ready", int'(ready), 0);
    check("reset_result_valid", int'(result_valid), 0);
    check("reset_motion_count", int'(motion_count), 0);
    check("reset_motion_detected", int'(motion_detected), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_protocol_err", int'(protocol_err), 0);

    // Plain frames, contiguous and gapped
    for (int k = 0; k < 4; k++) begin
      do_start();
      feed_pixels(vecs[k]);
      ack_idle(int'(vecs[k].exp_cnt));
    end

    // Back-to-back: ack with start re-enters ACCUM in the same cycle
    do_start();
    feed_pixels(vecs[4]);
    result_ack = 1'b1;
    start      = 1'b1;
    step();
    result_ack = 1'b0;
    start      = 1'b0;
    check("b2b_result_valid", int'(result_valid), 0);
    check("b2b_ready", int'(ready), 1);
    check("b2b_busy", int'(busy), 1);
    check("b2b_count_held", int'(motion_count), 2);
    feed_pixels(vecs[5]);

    // Hold REPORT for 10 cycles with start toggling and no ack
    for (int c = 0; c < 10; c++) begin
      start = ~start;
      step();
      check("hold_result_valid", int'(result_valid), 1);
      check("hold_ready", int'(ready), 0);
      check("hold_count", int'(motion_count), 3);
    end
    start = 1'b0;
    ack_idle(3);

    // Reset after 5 valids discards the frame
    do_start();
    for (int i = 0; i < 5; i++) begin
      valid_data       = 1'b1;
      frame_difference = 1'b1;
      step();
    end
    valid_data       = 1'b0;
    frame_difference = 1'b0;
    apply_reset();
    check("midreset_ready", int'(ready), 0);
    check("midreset_result_valid", int'(result_valid), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_motion_count", int'(motion_count), 0);
    check("midreset_motion_detected", int'(motion_detected), 0);
    step();
    step();
    do_start();
    feed_pixels(vecs[0]);
    ack_idle(3);

    // valid_data in IDLE sets a sticky error without counting
    valid_data       = 1'b1;
    frame_difference = 1'b1;
    step();
    valid_data       = 1'b0;
    frame_difference = 1'b0;
    check("perr_set", int'(protocol_err), 1);
    check("perr_busy", int'(busy), 0);
    step();
    step();
    check("perr_sticky", int'(protocol_err), 1);
    do_start();
    feed_pixels(vecs[4]);
    ack_idle(2);
    check("perr_still_set", int'(protocol_err), 1);
    apply_reset();
    check("perr_cleared", int'(protocol_err), 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
